// File: rtl/io_seq_pkg.sv
// io_seq_pkg: shared types and constants for the I/O output sequencer.
// Holds the sequencer state enum and well-known device numbers.
package io_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } seq_state_t;

    localparam int DEV_NUM_VAL  = 0;
    localparam int DEV_NUM_MODE = 1;
    localparam int DEV_CHAR     = 4;

endpackage

// File: rtl/io_seq_ctrl_if.sv
// io_seq_ctrl_if: CPU write port plus device bank bus of the sequencer.
// slave = sequencer side, master = CPU/device-bank side.
interface io_seq_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int NDEV   = 8
);
    import io_seq_pkg::*;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic [ADDR_W-1:0] dev_addr;
    logic [DATA_W-1:0] dev_data;
    logic [NDEV-1:0]   dev_load_n;
    logic [NDEV-1:0]   dev_busy;

    modport slave (
        input  wr_valid, wr_addr, wr_data, dev_busy,
        output wr_full, dev_addr, dev_data, dev_load_n
    );

    modport master (
        output wr_valid, wr_addr, wr_data, dev_busy,
        input  wr_full, dev_addr, dev_data, dev_load_n
    );

endinterface

// File: rtl/io_seq_fifo.sv
// io_seq_fifo: synchronous FIFO with push/pop/flush, DEPTH a power of two.
// Ports: clk, reset, flush, push, pop, din -> dout (head), full, empty.
module io_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    // Full is judged on the registered count: a pop never frees
    // space for a write in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_seq_ctrl.sv
// io_seq_ctrl: buffers CPU OUT writes and drains them to the device bank,
// one strobed transfer at a time (SETUP -> STROBE -> HOLD).
// Ports: clk, reset, out_rst (flush), bus (io_seq_ctrl_if.slave), idle,
// drop_cnt (only with IO_SEQ_DROPCNT_EN defined).
module io_seq_ctrl
    import io_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3,
    parameter int NDEV   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         out_rst,
    io_seq_ctrl_if.slave bus,
    output logic         idle
`ifdef IO_SEQ_DROPCNT_EN
    ,
    output logic [7:0]   drop_cnt
`endif
);
    localparam int W = ADDR_W + DATA_W;

    seq_state_t        state;
    seq_state_t        state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [NDEV-1:0]   load_n_q;
    logic [W-1:0]      head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              fire;
    logic              oor;

    assign push = bus.wr_valid & ~full & ~out_rst;
    assign oor  = 32'(addr_q) >= NDEV;

    io_seq_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (out_rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.wr_addr, bus.wr_data}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        fire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !out_rst) begin
                    pop      = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (oor || out_rst) begin
                    state_nx = IDLE;
                end else if (!bus.dev_busy[addr_q]) begin
                    fire     = 1'b1;
                    state_nx = STROBE;
                end
            end
            STROBE: state_nx = HOLD;
            HOLD: begin
                if (!empty && !out_rst) begin
                    pop      = 1'b1;
                    state_nx = SETUP;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Strobe is registered so it is a clean one-cycle pulse while in STROBE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            load_n_q <= '1;
        end else begin
            state    <= state_nx;
            load_n_q <= fire ? ~(NDEV'(1) << addr_q) : '1;
            if (pop) begin
                addr_q <= head[W-1:DATA_W];
                data_q <= head[DATA_W-1:0];
            end
        end
    end

    assign bus.wr_full    = full;
    assign bus.dev_addr   = addr_q;
    assign bus.dev_data   = data_q;
    assign bus.dev_load_n = load_n_q;
    assign idle           = (state == IDLE) && empty;

`ifdef IO_SEQ_DROPCNT_EN
    logic [7:0] drop_q;
    logic [8:0] drop_sum;
    logic       rej;
    logic       oor_drop;

    assign rej      = bus.wr_valid & full & ~out_rst;
    assign oor_drop = (state == SETUP) && oor;
    assign drop_sum = {1'b0, drop_q} + 9'(rej) + 9'(oor_drop);

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule
